// File: rtl/clk_reset_sequencer.sv
// clk_reset_sequencer
//
// Clock bring-up controller. It sequences the PLL reset, waits for PLL lock,
// sequences the downstream DCM reset, waits for DCM lock, then releases the
// per-domain resets one at a time, STAGGER cycles apart. Both locks are
// watched continuously. A lock loss while releasing or running restarts the
// sequence. A lock timeout is retried, and MAX_RETRY consecutive timeouts
// latch FAULT until RESTART or rst_n.
//
// Ports
//   clk         in   free-running oscillator clock
//   rst_n       in   asynchronous active-low reset, clears all state
//   pll_locked  in   PLL LOCKED, asynchronous (2-FF synchronised here)
//   dcm_locked  in   DCM LOCKED, asynchronous (2-FF synchronised here)
//   restart     in   clk-domain pulse, forces a full re-sequence and clears FAULT
//   pll_rst     out  active-high PLL reset
//   dcm_rst     out  active-high DCM reset
//   dom_rst_n   out  [N_DOM] per-domain active-low reset requests
//   all_ready   out  high only in RUN
//   fault       out  high in FAULT (sticky)
//   retry_cnt   out  [4] consecutive lock timeouts, cleared on reaching RUN
//   loss_cnt    out  [8] lock losses seen in RELEASE/RUN, saturates at 255
//   state       out  [3] current state code
module clk_reset_sequencer #(
  parameter int N_DOM     = 4,
  parameter int RST_PULSE = 16,
  parameter int LOCK_WAIT = 4096,
  parameter int STAGGER   = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             dcm_locked,
  input  logic             restart,
  output logic             pll_rst,
  output logic             dcm_rst,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             all_ready,
  output logic             fault,
  output logic [3:0]       retry_cnt,
  output logic [7:0]       loss_cnt,
  output logic [2:0]       state
);

  localparam int CNT_MAX = (LOCK_WAIT > N_DOM * STAGGER) ? LOCK_WAIT : N_DOM * STAGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] REL_DONE   = CW'(N_DOM * STAGGER);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
  localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL  = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_RST_DCM  = 3'd2,
    ST_WAIT_DCM = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [3:0]        retry_nxt;
  logic [3:0]        retry_inc;
  logic [7:0]        loss_nxt;
  logic [N_DOM-1:0]  dom_nxt;
  logic              pll_meta;
  logic              pll_s;
  logic              dcm_meta;
  logic              dcm_s;
  logic              lock_ok;
  logic              timeout;

  assign state = cur_state;

  // Next-state, counter and counter-output decode. Every registered output is
  // computed from the next state so that the flops themselves drive the pins.
  always_comb begin
    nxt_state = cur_state;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    dom_nxt   = dom_rst_n;
    lock_ok   = pll_s && dcm_s;
    timeout   = (cnt == WAIT_LAST);
    retry_inc = retry_cnt + 4'd1;

    if (restart) begin
      nxt_state = ST_RST_PLL;
      retry_nxt = 4'd0;
    end else begin
      case (cur_state)
        ST_RST_PLL: begin
          if (cnt == PULSE_LAST) nxt_state = ST_WAIT_PLL;
        end
        ST_WAIT_PLL: begin
          if (pll_s) begin
            nxt_state = ST_RST_DCM;
          end else if (timeout) begin
            retry_nxt = retry_inc;
            nxt_state = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RST_PLL;
          end
        end
        ST_RST_DCM: begin
          if (!pll_s) nxt_state = ST_RST_PLL;
          else if (cnt == PULSE_LAST) nxt_state = ST_WAIT_DCM;
        end
        ST_WAIT_DCM: begin
          // PLL loss restarts without counting as a retry
          if (!pll_s) begin
            nxt_state = ST_RST_PLL;
          end else if (dcm_s) begin
            nxt_state = ST_RELEASE;
          end else if (timeout) begin
            retry_nxt = retry_inc;
            nxt_state = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RST_PLL;
          end
        end
        ST_RELEASE: begin
          if (!lock_ok) begin
            if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
            nxt_state = ST_RST_PLL;
          end else if (cnt == REL_DONE) begin
            nxt_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lock_ok) begin
            if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
            nxt_state = ST_RST_PLL;
          end
        end
        ST_FAULT: begin
          nxt_state = ST_FAULT;
        end
        default: begin
          nxt_state = ST_RST_PLL;
        end
      endcase
    end

    if (nxt_state == ST_RUN) retry_nxt = 4'd0;

    // RESTART counts as a re-entry even when already in RST_PLL
    if (restart || (nxt_state != cur_state)) cnt_nxt = '0;
    else if (cnt != CNT_SAT)                 cnt_nxt = cnt + 1'b1;
    else                                     cnt_nxt = cnt;

    // Bit k rises on the edge where the counter reaches (k+1)*STAGGER; bits
    // hold through RUN and clear whenever the sequence leaves RELEASE/RUN.
    if (nxt_state == ST_RELEASE) begin
      for (int k = 0; k < N_DOM; k++) begin
        if (cnt_nxt == CW'((k + 1) * STAGGER)) dom_nxt[k] = 1'b1;
      end
    end else if (nxt_state != ST_RUN) begin
      dom_nxt = '0;
    end
  end

  // State, counter, lock synchronisers and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_RST_PLL;
      cnt       <= '0;
      pll_meta  <= 1'b0;
      pll_s     <= 1'b0;
      dcm_meta  <= 1'b0;
      dcm_s     <= 1'b0;
      pll_rst   <= 1'b1;
      dcm_rst   <= 1'b1;
      dom_rst_n <= '0;
      all_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      pll_meta  <= pll_locked;
      pll_s     <= pll_meta;
      dcm_meta  <= dcm_locked;
      dcm_s     <= dcm_meta;
      pll_rst   <= (nxt_state == ST_RST_PLL) || (nxt_state == ST_FAULT);
      dcm_rst   <= (nxt_state == ST_RST_PLL) || (nxt_state == ST_WAIT_PLL) ||
                   (nxt_state == ST_RST_DCM) || (nxt_state == ST_FAULT);
      dom_rst_n <= dom_nxt;
      all_ready <= (nxt_state == ST_RUN);
      fault     <= (nxt_state == ST_FAULT);
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb_clk_reset_sequencer
//
// Directed bench for clk_reset_sequencer with N_DOM=3, RST_PULSE=4,
// LOCK_WAIT=100, STAGGER=8, MAX_RETRY=3. Inputs are driven and outputs
// sampled 1ns after each rising edge.
module tb_clk_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       dcm_locked;
  logic       restart;
  logic       pll_rst;
  logic       dcm_rst;
  logic [2:0] dom_rst_n;
  logic       all_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int total;
  int bad;

  typedef struct {
    int         cyc;
    logic       pll;
    logic       dcm;
    logic [2:0] st;
    logic       prst;
    logic       drst;
    logic [2:0] dom;
    logic       rdy;
    logic       flt;
    logic [3:0] rc;
    logic [7:0] lc;
  } vec_t;

  vec_t vecs [17];

  clk_reset_sequencer #(
    .N_DOM(3), .RST_PULSE(4), .LOCK_WAIT(100), .STAGGER(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .dcm_locked(dcm_locked),
    .restart(restart), .pll_rst(pll_rst), .dcm_rst(dcm_rst), .dom_rst_n(dom_rst_n),
    .all_ready(all_ready), .fault(fault), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [21:0] pack(logic [2:0] st, logic p, logic d, logic [2:0] dom,
                                       logic r, logic f, logic [3:0] rc, logic [7:0] lc);
    return {st, p, d, dom, r, f, rc, lc};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pll, input logic dcm, input logic rs);
    pll_locked = pll;
    dcm_locked = dcm;
    restart    = rs;
  endtask

  task automatic checkOutput(input string name, input logic [21:0] want);
    logic [21:0] got;
    got = pack(state, pll_rst, dcm_rst, dom_rst_n, all_ready, fault, retry_cnt, loss_cnt);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got st=%0d prst=%b drst=%b dom=%b rdy=%b flt=%b rc=%0d lc=%0d want st=%0d prst=%b drst=%b dom=%b rdy=%b flt=%b rc=%0d lc=%0d",
               name, got[21:19], got[18], got[17], got[16:14], got[13], got[12], got[11:8], got[7:0],
               want[21:19], want[18], want[17], want[16:14], want[13], want[12], want[11:8], want[7:0]);
    end
  endtask

  task automatic checkLoss(input string name, input logic [7:0] want);
    total++;
    if (loss_cnt !== want) begin
      bad++;
      $display("[TB] FAIL %s loss_cnt got=%0d want=%0d", name, loss_cnt, want);
    end
  endtask

  task automatic waitState(input string name, input logic [2:0] st, input int limit);
    int i;
    i = 0;
    while (state !== st && i < limit) begin
      tick(1);
      i++;
    end
    if (state !== st) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timed out waiting for state got=%0d want=%0d", name, state, st);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Nominal bring-up: inputs applied, then cyc edges, then compared
    vecs[0]  = '{3, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[1]  = '{1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[2]  = '{6, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[3]  = '{2, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[4]  = '{1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[5]  = '{3, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[6]  = '{1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[7]  = '{3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[8]  = '{2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[9]  = '{1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[10] = '{7, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[11] = '{1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[12] = '{8, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[13] = '{7, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[14] = '{1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[15] = '{1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd0};
    vecs[16] = '{5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("reset_state", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].pll, vecs[i].dcm, 1'b0);
      tick(vecs[i].cyc);
      checkOutput($sformatf("nominal_vec%0d", i),
                  pack(vecs[i].st, vecs[i].prst, vecs[i].drst, vecs[i].dom,
                       vecs[i].rdy, vecs[i].flt, vecs[i].rc, vecs[i].lc));
    end

    // Lock loss in RUN: one-cycle DCM drop
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("run_loss_still_run", pack(3'd5, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd0));
    tick(1);
    checkOutput("run_loss_cleared", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1));
    tick(34);
    checkOutput("resequence_release", pack(3'd4, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1));
    tick(1);
    checkOutput("resequence_run", pack(3'd5, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd1));

    // RESTART from RUN, then a PLL drop after bit 0 is released
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_from_run", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1));
    tick(18);
    checkOutput("release_bit0", pack(3'd4, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd1));
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("release_loss_pending", pack(3'd4, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd1));
    tick(1);
    checkOutput("release_loss", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2));

    // Asynchronous reset in the middle of RELEASE
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(18);
    checkOutput("pre_reset_release", pack(3'd4, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd2));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0));
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;

    // Lock timeout: three retries, then FAULT
    tick(103);
    checkOutput("timeout1_wait", pack(3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0));
    tick(1);
    checkOutput("timeout1", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd1, 8'd0));
    tick(103);
    checkOutput("timeout2_wait", pack(3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd1, 8'd0));
    tick(1);
    checkOutput("timeout2", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd2, 8'd0));
    tick(103);
    checkOutput("timeout3_wait", pack(3'd1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd2, 8'd0));
    tick(1);
    checkOutput("fault_entry", pack(3'd6, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 4'd3, 8'd0));
    tick(8);
    checkOutput("fault_held", pack(3'd6, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 4'd3, 8'd0));
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fault_restart", pack(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0));

    // LOSS_CNT saturation: 300 lock losses during RELEASE
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int ev = 0; ev < 300; ev++) begin
      waitState("sat_release", 3'd4, 60);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitState("sat_rst_pll", 3'd0, 10);
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (ev == 99)  checkLoss("loss_100", 8'd100);
      if (ev == 254) checkLoss("loss_255", 8'd255);
      if (ev == 255) checkLoss("loss_sat_256", 8'd255);
    end
    checkLoss("loss_sat_300", 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
